iq_amplitude: RTL and testbench
===============================

# iq_amplitude

Pipelined amplitude stage that converts a stream of signed I/Q sample pairs into one unsigned amplitude word per input sample. Its `amplitude`/`load_val` style output feeds the block averager directly. It sits between the mixer/decimator output and the averager. Two per-sample modes are supported: exact power (I²+Q²) and a multiplier-free magnitude estimate (alpha-max-plus-beta-min). Saturation is detected and latched in a sticky flag.

## Interface
- `IQBITS`, 16: width of the signed I and Q inputs (two's complement).
- `NBITS`, 32: output amplitude width. Must match the averager's `NBITS`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `iq_valid`  in  1  qualifies `i_data`/`q_data`/`mode` for one cycle.
- `i_data`  in  IQBITS  signed in-phase sample.
- `q_data`  in  IQBITS  signed quadrature sample.
- `mode`  in  1  0 = power I²+Q²; 1 = magnitude estimate. Sampled with each valid sample.
- `sat_clr`  in  1  clears `sat_flag`.
- `amplitude`  out  NBITS  unsigned result, connects to the averager's `amplitude` input.
- `load_val`  out  1  one-cycle strobe qualifying `amplitude`, connects to the averager's `load_val` input.
- `sat_flag`  out  1  sticky flag: at least one result was clipped since the last clear or reset.

## Operation
- Three-stage pipeline with one valid bit per stage. Accepts one sample per cycle with no backpressure. Bubbles (`iq_valid`=0) propagate as bubbles.
- `mode` is registered at stage 1 and travels with its sample. Back-to-back samples of different modes are each computed in their own mode.
- Stage 1: absolute values |I| and |Q| as IQBITS-bit unsigned values. -2^(IQBITS-1) maps to 2^(IQBITS-1) exactly, with no wrap.
- Stage 2:
  - Power mode: registers |I|² and |Q|², each 2·IQBITS bits.
  - Magnitude mode: registers mx = max(|I|,|Q|) and mn = min(|I|,|Q|).
- Stage 3, full-precision sum at 2·IQBITS+1 bits:
  - Power mode: |I|²+|Q|².
  - Magnitude mode: mx + (mn>>2) + (mn>>3), with truncating shifts.
- Saturation:
  - If the sum exceeds 2^NBITS−1, `amplitude` = 2^NBITS−1 and `sat_flag` is set.
  - Otherwise the sum is zero-extended or truncated to NBITS. With the defaults, no clipping is possible: the maximum power is 2^31.
- `sat_flag`:
  - Set by any clipped valid result.
  - Cleared by `sat_clr`.
  - If set and clear occur in the same cycle, set wins.
- `amplitude` holds its last value while `load_val`=0.

## Timing
- Latency is 3 cycles: a sample with `iq_valid` high at edge N produces `load_val`=1 for exactly one cycle after edge N+3, with `amplitude` valid in that same cycle.
- Throughput is 1 sample per clock. N consecutive valid inputs produce N consecutive `load_val` strobes.
- Reset values: `amplitude`=0, `load_val`=0, `sat_flag`=0. All stage valid bits and data registers are 0.
- Reset mid-operation: every in-flight sample is discarded and no `load_val` is issued for it. The first sample accepted after `rst` deasserts appears 3 cycles later.
- `iq_valid` asserted during `rst` is ignored.
- `sat_clr` takes effect at the next edge. `sat_flag` reads 0 in the following cycle, unless a clip is being registered at that same edge.

## Test plan
- Power, basic: I=-1000, Q=400, mode=0, single strobe -> exactly 3 cycles later `load_val`=1 for one cycle with `amplitude`=1160000, and `sat_flag`=0.
- Magnitude estimate: I=-1000, Q=400, mode=1 -> `amplitude`=1150. Also I=3, Q=4, mode=1 -> 4.
- Full-scale and saturation:
  - I=Q=-32768, mode=0, defaults -> 2147483648, `sat_flag`=0.
  - Same input with NBITS=24 -> `amplitude`=16777215 and `sat_flag`=1.
  - Assert `sat_clr` in the same cycle as another clipped result -> `sat_flag` stays 1.
  - Assert `sat_clr` alone -> `sat_flag`=0.
- Streaming with mixed modes and bubbles: 8 back-to-back samples alternating mode, then pattern valid, bubble, valid -> outputs match the per-sample model in order, strobes mirror the input gaps, and `amplitude` holds during gaps.
- Reset mid-pipeline: 3 samples in flight, pulse `rst` for 1 cycle -> no `load_val` for them, all outputs 0. A new sample fed right after reset emerges after 3 cycles.
- Integration with the averager (STOPAT=320): 321 consecutive samples of I=16, Q=0, mode=0 -> the averager's `valid` asserts on the 321st `load_val`.

Source files
------------

// File: rtl/iq_amplitude.sv
// I/Q amplitude stage: turns signed I/Q pairs into an unsigned amplitude word.
// Each sample selects exact power (I^2+Q^2) or alpha-max-plus-beta-min magnitude.
module iq_amplitude #(
  parameter int IQBITS = 16,
  parameter int NBITS  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iq_valid,
  input  logic signed [IQBITS-1:0] i_data,
  input  logic signed [IQBITS-1:0] q_data,
  input  logic                     mode,
  input  logic                     sat_clr,
  output logic [NBITS-1:0]         amplitude,
  output logic                     load_val,
  output logic                     sat_flag
);

  localparam int PW = 2 * IQBITS;
  localparam int SW = PW + 1;

  logic [2:0]        vld_pipe_q, vld_pipe_d;

  logic [IQBITS-1:0] abs_i_q, abs_i_d;
  logic [IQBITS-1:0] abs_q_q, abs_q_d;
  logic              mode1_q;

  logic [PW-1:0]     p0_q, p0_d;
  logic [PW-1:0]     p1_q, p1_d;
  logic              mode2_q;

  logic [NBITS-1:0]  amp_q, amp_d;
  logic              sat_q, sat_d;

  logic [PW-1:0]     sq_i, sq_q;
  logic [IQBITS-1:0] mx, mn;
  logic [SW-1:0]     sum;
  logic              clip;

  // Stage 1: the IQBITS-bit negate of the most negative code is 2^(IQBITS-1)
  // when read as unsigned, so full-scale negative needs no extra bit.
  always_comb begin
    abs_i_d = i_data[IQBITS-1] ? IQBITS'(-i_data) : IQBITS'(i_data);
    abs_q_d = q_data[IQBITS-1] ? IQBITS'(-q_data) : IQBITS'(q_data);
  end

  // Stage 2 shares one register pair: squares in power mode, max/min otherwise.
  always_comb begin
    sq_i = PW'(abs_i_q) * PW'(abs_i_q);
    sq_q = PW'(abs_q_q) * PW'(abs_q_q);
    mx   = (abs_i_q >= abs_q_q) ? abs_i_q : abs_q_q;
    mn   = (abs_i_q >= abs_q_q) ? abs_q_q : abs_i_q;
    p0_d = mode1_q ? PW'(mx) : sq_i;
    p1_d = mode1_q ? PW'(mn) : sq_q;
  end

  // Stage 3: full-precision sum; magnitude uses mx + mn*(1/4 + 1/8).
  always_comb begin
    if (mode2_q)
      sum = SW'(p0_q) + SW'(p1_q >> 2) + SW'(p1_q >> 3);
    else
      sum = SW'(p0_q) + SW'(p1_q);
  end

  generate
    if (SW > NBITS) begin : g_clip
      assign clip  = |sum[SW-1:NBITS];
      assign amp_d = clip ? {NBITS{1'b1}} : sum[NBITS-1:0];
    end else begin : g_noclip
      assign clip  = 1'b0;
      assign amp_d = NBITS'(sum);
    end
  endgenerate

  // A clip registered on the same edge as a clear wins.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[1:0], iq_valid};
    if (vld_pipe_q[1] && clip)
      sat_d = 1'b1;
    else if (sat_clr)
      sat_d = 1'b0;
    else
      sat_d = sat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      abs_i_q    <= '0;
      abs_q_q    <= '0;
      mode1_q    <= 1'b0;
      p0_q       <= '0;
      p1_q       <= '0;
      mode2_q    <= 1'b0;
      amp_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sat_q      <= sat_d;
      if (iq_valid) begin
        abs_i_q <= abs_i_d;
        abs_q_q <= abs_q_d;
        mode1_q <= mode;
      end
      if (vld_pipe_q[0]) begin
        p0_q    <= p0_d;
        p1_q    <= p1_d;
        mode2_q <= mode1_q;
      end
      if (vld_pipe_q[1])
        amp_q <= amp_d;
    end
  end

  assign amplitude = amp_q;
  assign load_val  = vld_pipe_q[2];
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iq_amplitude.sv
// Directed bench for iq_amplitude: default (NBITS=32) and narrow (NBITS=24) instances.
module tb_iq_amplitude;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               iq_valid = 1'b0;
  logic signed [15:0] i_data = '0;
  logic signed [15:0] q_data = '0;
  logic               mode = 1'b0;
  logic               sat_clr = 1'b0;

  logic [31:0] amp32;
  logic        load32, sat32;
  logic [23:0] amp24;
  logic        load24, sat24;

  int errors = 0;
  int checks = 0;
  longint unsigned hold32 = 0;

  always #5 clk = ~clk;

  iq_amplitude #(.IQBITS(16), .NBITS(32)) dut32 (
    .clk(clk), .rst(rst), .iq_valid(iq_valid), .i_data(i_data), .q_data(q_data),
    .mode(mode), .sat_clr(sat_clr), .amplitude(amp32), .load_val(load32), .sat_flag(sat32));

  iq_amplitude #(.IQBITS(16), .NBITS(24)) dut24 (
    .clk(clk), .rst(rst), .iq_valid(iq_valid), .i_data(i_data), .q_data(q_data),
    .mode(mode), .sat_clr(sat_clr), .amplitude(amp24), .load_val(load24), .sat_flag(sat24));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int i, input int q, input bit m);
    iq_valid = v;
    i_data   = 16'(i);
    q_data   = 16'(q);
    mode     = m;
  endtask

  // Independent reference for the 32-bit instance (never clips with 16-bit inputs).
  function automatic longint unsigned model(input int i, input int q, input bit m);
    longint ai, aq, mx, mn;
    ai = (i < 0) ? -i : i;
    aq = (q < 0) ? -q : q;
    if (!m) return longint'(ai * ai + aq * aq);
    mx = (ai > aq) ? ai : aq;
    mn = (ai > aq) ? aq : ai;
    return longint'(mx + mn / 4 + mn / 8);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 100, 100, 0);
    step(); step();
    checks++; if (load32 !== 1'b0) begin errors++; $display("FAIL reset_load got %0b want 0", load32); end
    checks++; if (amp32 !== 32'd0) begin errors++; $display("FAIL reset_amp got %0d want 0", amp32); end
    checks++; if (sat32 !== 1'b0 || sat24 !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b/%0b want 0/0", sat32, sat24); end
    drive(0, 0, 0, 0);
    rst = 1'b0;
    step();
    hold32 = 0;
  endtask

  task automatic test_power_basic();
    drive(1, -1000, 400, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    checks++; if (load32 !== 1'b0) begin errors++; $display("FAIL pwr_early_load got %0b want 0", load32); end
    step();
    checks++; if (load32 !== 1'b1) begin errors++; $display("FAIL pwr_load got %0b want 1", load32); end
    checks++; if (amp32 !== 32'd1160000) begin errors++; $display("FAIL pwr_amp got %0d want 1160000", amp32); end
    checks++; if (sat32 !== 1'b0) begin errors++; $display("FAIL pwr_sat got %0b want 0", sat32); end
    step();
    checks++; if (load32 !== 1'b0) begin errors++; $display("FAIL pwr_strobe_len got %0b want 0", load32); end
    checks++; if (amp32 !== 32'd1160000) begin errors++; $display("FAIL pwr_hold got %0d want 1160000", amp32); end
    hold32 = 1160000;
  endtask

  task automatic test_magnitude();
    drive(1, -1000, 400, 1);
    step();
    drive(1, 3, 4, 1);
    step();
    drive(0, 0, 0, 0);
    step();
    checks++; if (load32 !== 1'b1 || amp32 !== 32'd1150) begin errors++; $display("FAIL mag_a got %0b/%0d want 1/1150", load32, amp32); end
    step();
    checks++; if (load32 !== 1'b1 || amp32 !== 32'd4) begin errors++; $display("FAIL mag_b got %0b/%0d want 1/4", load32, amp32); end
    step();
    hold32 = 4;
  endtask

  task automatic test_full_scale();
    drive(1, -32768, -32768, 0);
    step();
    drive(0, 0, 0, 0);
    step(); step();
    checks++; if (amp32 !== 32'd2147483648) begin errors++; $display("FAIL fs_amp32 got %0d want 2147483648", amp32); end
    checks++; if (sat32 !== 1'b0) begin errors++; $display("FAIL fs_sat32 got %0b want 0", sat32); end
    checks++; if (amp24 !== 24'd16777215 || load24 !== 1'b1) begin errors++; $display("FAIL fs_amp24 got %0d/%0b want 16777215/1", amp24, load24); end
    checks++; if (sat24 !== 1'b1) begin errors++; $display("FAIL fs_sat24 got %0b want 1", sat24); end
    step();
    hold32 = 64'd2147483648;
  endtask

  task automatic test_saturation();
    // Clear arrives on the same edge as another clipped result.
    drive(1, -32768, -32768, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    sat_clr = 1'b1;
    step();
    checks++; if (sat24 !== 1'b1) begin errors++; $display("FAIL sat_set_wins got %0b want 1", sat24); end
    step();
    sat_clr = 1'b0;
    checks++; if (sat24 !== 1'b0) begin errors++; $display("FAIL sat_clr got %0b want 0", sat24); end
    step();
    checks++; if (sat24 !== 1'b0) begin errors++; $display("FAIL sat_stays_clr got %0b want 0", sat24); end
  endtask

  task automatic test_back_to_back();
    int ti[11] = '{-1000, 3, 32767, -32768, 1234, -5, 0, 700, -300, 9, 20000};
    int tq[11] = '{400, 4, -1, 100, -4321, -5, 0, -700, 50, 0, -20000};
    bit tm[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0};
    bit tv[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    int bad = 0;
    longint unsigned exp_amp;
    for (int c = 0; c < 15; c++) begin
      if (c >= 3 && c - 3 < 11 && tv[c-3]) begin
        exp_amp = model(ti[c-3], tq[c-3], tm[c-3]);
        hold32  = exp_amp;
        checks++;
        if (load32 !== 1'b1 || amp32 !== 32'(exp_amp)) begin
          errors++; bad++;
          $display("FAIL stream_out[%0d] got %0b/%0d want 1/%0d", c - 3, load32, amp32, exp_amp);
        end
      end else begin
        checks++;
        if (load32 !== 1'b0 || amp32 !== 32'(hold32)) begin
          errors++; bad++;
          $display("FAIL stream_gap[%0d] got %0b/%0d want 0/%0d", c, load32, amp32, hold32);
        end
      end
      if (c < 11) drive(tv[c], ti[c], tq[c], tm[c]);
      else        drive(0, 0, 0, 0);
      step();
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 100, 200, 0);
    step();
    drive(1, 300, 400, 1);
    step();
    drive(1, -32768, -32768, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (load32 !== 1'b0 || amp32 !== 32'd0) begin errors++; $display("FAIL rstmid_out got %0b/%0d want 0/0", load32, amp32); end
    checks++; if (sat32 !== 1'b0 || sat24 !== 1'b0) begin errors++; $display("FAIL rstmid_sat got %0b/%0b want 0/0", sat32, sat24); end
    drive(1, 6, -8, 0);
    step();
    drive(0, 0, 0, 0);
    checks++; if (load32 !== 1'b0) begin errors++; $display("FAIL rstmid_flush1 got %0b want 0", load32); end
    step();
    checks++; if (load32 !== 1'b0) begin errors++; $display("FAIL rstmid_flush2 got %0b want 0", load32); end
    step();
    checks++; if (load32 !== 1'b1 || amp32 !== 32'd100) begin errors++; $display("FAIL rstmid_new got %0b/%0d want 1/100", load32, amp32); end
    step();
    hold32 = 100;
  endtask

  task automatic test_long_run();
    int strobes = 0;
    int bad = 0;
    int last_c = -1;
    for (int c = 0; c < 330; c++) begin
      if (load32 === 1'b1) begin
        strobes++;
        last_c = c;
        if (amp32 !== 32'd256) bad++;
      end
      if (c < 321) drive(1, 16, 0, 0);
      else         drive(0, 0, 0, 0);
      step();
    end
    checks++; if (strobes != 321) begin errors++; $display("FAIL long_strobes got %0d want 321", strobes); end
    checks++; if (bad != 0) begin errors++; $display("FAIL long_amp got %0d bad want 0 bad", bad); end
    checks++; if (last_c != 323) begin errors++; $display("FAIL long_last_cycle got %0d want 323", last_c); end
  endtask

  initial begin
    test_reset();
    test_power_basic();
    test_magnitude();
    test_full_scale();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_long_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
